// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
// Runtime-configurable UART transmitter: 5..MAX_DATA_W data bits, optional parity, 1/2 stop, break.
// Start bit appears the cycle after accept; ready only in IDLE without break, config frozen per frame.
module uart_tx_cfg #(
  parameter int unsigned MAX_DATA_W = 9,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned BITS_W     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [MAX_DATA_W-1:0] tx_data_i,
  input  logic [BITS_W-1:0]     data_bits_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  input  logic [CNT_W-1:0]      clks_per_bit_i,
  input  logic                  break_i,
  output logic                  tx_o,
  output logic                  tx_busy_o,
  output logic                  tx_done_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BITS_W-1:0]     idx_q, idx_d;
  logic [MAX_DATA_W-1:0] shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic [CNT_W-1:0]      cpb_q;
  logic [BITS_W-1:0]     bits_q;
  logic                  pen_q;
  logic                  stop2_q;
  logic                  par_q;

  logic [BITS_W-1:0]     bits_eff;
  logic [MAX_DATA_W-1:0] data_mask;
  logic [CNT_W-1:0]      cpb_eff;
  logic                  accept;
  logic                  bit_end;
  logic                  last_data;
  logic                  last_stop;

  assign tx_ready_o = rst_ni && (state_q == ST_IDLE) && !break_i;
  assign accept     = tx_valid_i && tx_ready_o;
  assign tx_busy_o  = (state_q != ST_IDLE);
  assign tx_o       = tx_q;
  assign tx_done_o  = done_q;

  // Out-of-range frame settings are clamped once, at accept time.
  always_comb begin
    bits_eff = data_bits_i;
    if (data_bits_i < BITS_W'(5)) begin
      bits_eff = BITS_W'(5);
    end else if (data_bits_i > BITS_W'(MAX_DATA_W)) begin
      bits_eff = BITS_W'(MAX_DATA_W);
    end
    data_mask = '0;
    for (int i = 0; i < int'(MAX_DATA_W); i++) begin
      data_mask[i] = (BITS_W'(i) < bits_eff);
    end
    cpb_eff = (clks_per_bit_i == '0) ? CNT_W'(1) : clks_per_bit_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cpb_q   <= CNT_W'(1);
      bits_q  <= BITS_W'(5);
      pen_q   <= 1'b0;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
    end else if (accept) begin
      cpb_q   <= cpb_eff;
      bits_q  <= bits_eff;
      pen_q   <= parity_en_i;
      stop2_q <= stop2_i;
      par_q   <= (^(tx_data_i & data_mask)) ^ parity_odd_i;
    end
  end

  assign bit_end   = (cnt_q == cpb_q - CNT_W'(1));
  assign last_data = (idx_q == bits_q - BITS_W'(1));
  assign last_stop = (idx_q == {{(BITS_W-1){1'b0}}, stop2_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (accept) begin
          state_d = ST_START;
          shreg_d = tx_data_i & data_mask;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (last_data) begin
            state_d = pen_q ? ST_PARITY : ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + BITS_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + BITS_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Line level is registered from the next state so the pad never glitches.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_q;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = !break_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_cfg: frames are captured one sample per bit and compared
// against hand-computed line patterns (bit i of the pattern = i-th bit period on tx_o).
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [8:0]  data;
  logic [3:0]  nbits;
  logic        pen;
  logic        podd;
  logic        s2;
  logic [15:0] cpb;
  logic        brk;
  logic        tx;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.MAX_DATA_W(9), .CNT_W(16), .BITS_W(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tx_valid_i     (valid),
    .tx_ready_o     (ready),
    .tx_data_i      (data),
    .data_bits_i    (nbits),
    .parity_en_i    (pen),
    .parity_odd_i   (podd),
    .stop2_i        (s2),
    .clks_per_bit_i (cpb),
    .break_i        (brk),
    .tx_o           (tx),
    .tx_busy_o      (busy),
    .tx_done_o      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends one frame, scrambles the inputs right after accept, and checks line pattern,
  // per-bit stability, busy duration and the done pulse that follows.
  task automatic run_frame(input string tag, input logic [8:0] d, input logic [3:0] b,
                           input logic p_en, input logic p_odd, input logic two_stop,
                           input logic [15:0] c_pb, input int ecpb, input int nb,
                           input logic [15:0] exp, input int brk_at);
    logic [15:0] obs;
    logic        stable;
    int          busy_n;
    int          done_n;
    @(negedge clk);
    data = d; nbits = b; pen = p_en; podd = p_odd; s2 = two_stop; cpb = c_pb; valid = 1'b1;
    check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = ~d; nbits = 4'd9; pen = ~p_en; podd = ~p_odd; s2 = ~two_stop; cpb = c_pb + 16'd3;
    obs = '0; stable = 1'b1; busy_n = 0; done_n = 0;
    for (int c = 0; c < nb * ecpb; c++) begin
      if (brk_at != 0 && c == brk_at) brk = 1'b1;
      @(negedge clk);
      if (c % ecpb == 0) obs[c / ecpb] = tx;
      else if (tx !== obs[c / ecpb]) stable = 1'b0;
      busy_n += int'(busy);
      done_n += int'(done);
    end
    check_eq({tag, "_frame"}, 32'(obs), 32'(exp));
    check_eq({tag, "_stable"}, 32'(stable), 32'd1);
    check_eq({tag, "_busy_len"}, 32'(busy_n), 32'(nb * ecpb));
    check_eq({tag, "_early_done"}, 32'(done_n), 32'd0);
    @(negedge clk);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_ready_end"}, 32'(ready), (brk_at == 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    check_eq({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] obs21;
    int          dn;
    int          tx_low;
    logic        gap_busy;

    rst_n = 1'b0; valid = 1'b0; data = '0; nbits = 4'd8; pen = 1'b0; podd = 1'b0;
    s2 = 1'b0; cpb = 16'd4; brk = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(ready), 32'd1);

    // 8N1 0xA5: 0 | 1 0 1 0 0 1 0 1 | 1
    run_frame("a5_8n1", 9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 16'd4, 4, 10, 16'h034A, 0);
    // 7E2 0x1BB: low 7 bits 1101110 (five ones) -> parity 1; bits 7/8 ignored
    run_frame("3b_7e2", 9'h1BB, 4'd7, 1'b1, 1'b0, 1'b1, 16'd3, 3, 11, 16'h0776, 0);
    // 9O1 0x1FF: nine ones -> odd parity bit 0
    run_frame("1ff_9o1", 9'h1FF, 4'd9, 1'b1, 1'b1, 1'b0, 16'd2, 2, 12, 16'h0BFE, 0);

    // Back-to-back, valid held: 0x55 then 0x0F at 1 clk/bit. The only high cycle between
    // the frames is the done/ready cycle in which the second frame is accepted.
    @(negedge clk);
    data = 9'h055; nbits = 4'd8; pen = 1'b0; podd = 1'b0; s2 = 1'b0; cpb = 16'd1; valid = 1'b1;
    obs21 = '0; dn = 0; gap_busy = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) data = 9'h00F;
      if (c == 3) begin nbits = 4'd5; pen = 1'b1; s2 = 1'b1; cpb = 16'd7; end
      if (c == 6) begin nbits = 4'd8; pen = 1'b0; s2 = 1'b0; cpb = 16'd1; end
      if (c == 12) valid = 1'b0;
      @(negedge clk);
      if (c <= 21) obs21[c-1] = tx;
      if (c == 11) gap_busy = busy;
      dn += int'(done);
    end
    check_eq("b2b_line", obs21, 32'h0010_F6AA);
    check_eq("b2b_done_cnt", 32'(dn), 32'd2);
    check_eq("b2b_gap_busy", 32'(gap_busy), 32'd0);

    // Break raised mid-frame: frame unchanged, then line held low while idle.
    run_frame("brk_mid", 9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 16'd5, 5, 10, 16'h0278, 17);
    valid = 1'b1;
    tx_low = 0;
    repeat (5) begin
      @(negedge clk);
      tx_low += int'(!tx && !ready && !busy);
    end
    check_eq("brk_hold", 32'(tx_low), 32'd5);
    @(posedge clk);
    #1;
    brk = 1'b0; valid = 1'b0;
    @(negedge clk);
    check_eq("brk_rel_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check_eq("brk_rel_tx", 32'(tx), 32'd1);
    check_eq("brk_rel_busy", 32'(busy), 32'd0);

    // Reset pulse during the DATA phase of an 8N1 frame.
    @(negedge clk);
    data = 9'h0A5; nbits = 4'd8; pen = 1'b0; s2 = 1'b0; cpb = 16'd4; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", 32'(tx), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dn = 0; tx_low = 0;
    repeat (10) begin
      @(negedge clk);
      dn += int'(done);
      tx_low += int'(!tx);
    end
    check_eq("post_rst_no_done", 32'(dn), 32'd0);
    check_eq("post_rst_line_high", 32'(tx_low), 32'd0);

    // data_bits 2 -> 5, clks_per_bit 0 -> 1: 0x1F6 low five bits 10110
    run_frame("clamp", 9'h1F6, 4'd2, 1'b0, 1'b0, 1'b0, 16'd0, 1, 7, 16'h006C, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
